// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back cache, 8 blocks x 4 bytes.
// Address split: tag[7:5], index[4:2], offset[1:0]. The CPU is stalled
// through BUSYWAIT while a miss is serviced with block-wide memory transfers.
module data_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] data_reg [8];
  logic [2:0]  tag_reg  [8];
  logic [7:0]  valid_reg;
  logic [7:0]  dirty_reg;
  // Block address {tag, index} of the request that missed; the fill keeps
  // using it even if the CPU drops or changes its request mid-miss.
  logic [5:0]  miss_addr_reg;
  logic [31:0] fill_reg;

  logic [2:0] req_tag;
  logic [2:0] req_index;
  logic [1:0] req_offset;
  logic [2:0] miss_index;
  logic       req;
  logic       hit;
  logic       miss;
  logic       store_hit;
  logic [7:0] fill_en;
  logic [7:0] store_en;

  assign req_tag    = ADDRESS[7:5];
  assign req_index  = ADDRESS[4:2];
  assign req_offset = ADDRESS[1:0];
  assign miss_index = miss_addr_reg[2:0];

  assign req       = READ | WRITE;
  assign hit       = valid_reg[req_index] & (tag_reg[req_index] == req_tag);
  assign miss      = (state_reg == IDLE) & req & ~hit;
  // READ and WRITE together act as a store.
  assign store_hit = (state_reg == IDLE) & WRITE & hit;

  assign READDATA = data_reg[req_index][{req_offset, 3'b000} +: 8];
  assign BUSYWAIT = ~RESET & ((state_reg != IDLE) | (req & ~hit));

  // Per-block write enables: whole-block fill from UPDATE, or a byte store hit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_blk_en
      assign fill_en[gi]  = (state_reg == UPDATE) & (miss_index == 3'(gi));
      assign store_en[gi] = store_hit & (req_index == 3'(gi));
    end
  endgenerate

  // Block storage: fill on UPDATE, byte merge on store hit, clear on reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        data_reg[i] <= '0;
        tag_reg[i]  <= '0;
      end
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (fill_en[i]) begin
          data_reg[i]  <= fill_reg;
          tag_reg[i]   <= miss_addr_reg[5:3];
          valid_reg[i] <= 1'b1;
          dirty_reg[i] <= 1'b0;
        end else if (store_en[i]) begin
          data_reg[i][{req_offset, 3'b000} +: 8] <= WRITEDATA;
          dirty_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Controller state, latched miss address and captured fill block.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      miss_addr_reg <= '0;
      fill_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (miss) begin
        miss_addr_reg <= ADDRESS[7:2];
      end
      if ((state_reg == FETCH) && !MEM_BUSYWAIT) begin
        fill_reg <= MEM_READDATA;
      end
    end
  end

  // Next-state and memory handshake outputs.
  always_comb begin
    state_next    = state_reg;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = miss_addr_reg;
    MEM_WRITEDATA = data_reg[miss_index];
    case (state_reg)
      IDLE: begin
        if (miss) begin
          if (valid_reg[req_index] & dirty_reg[req_index]) begin
            state_next = WRITE_BACK;
          end else begin
            state_next = FETCH;
          end
        end
      end
      WRITE_BACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_reg[miss_index], miss_index};
        if (!MEM_BUSYWAIT) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
